mux4_rr: RTL and testbench

MUX4_RR -- requirements
Module: mux4_rr

---
 rtl/mux4_rr_pkg.sv | 44 ++++
 rtl/mux4_rr_if.sv | 31 +++
 rtl/rr_arbiter4.sv | 69 ++++++
 rtl/mux4_rr.sv | 74 +++++++
 tb/tb_mux4_rr.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux4_pkg
// Purpose  : Shared constants, arbiter state type and small helper functions
//            for the 4:1 round-robin packet multiplexer.
// Revision : 1.0
// ============================================================================
package mux4_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Round-robin search starting one past ptr; returns {found, index}.
  // Iterating from lowest to highest priority lets the highest-priority
  // hit overwrite the others.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_CH-1:0]  valid,
                                             input logic [SEL_W-1:0] ptr);
    logic [SEL_W:0]   r;
    logic [SEL_W-1:0] idx;
    r = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = ptr + SEL_W'(i);
      if (valid[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // One-hot to binary index; zero vector maps to index 0.
  function automatic logic [SEL_W-1:0] onehot_idx(input logic [N_CH-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_if
// Purpose  : Input-channel and output-stream handshake bundle of mux4_rr.
//            master = traffic source/sink side, slave = the multiplexer.
// Revision : 1.0
// ============================================================================
interface mux4_rr_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_last;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_last;
  logic               out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : 4-channel round-robin arbiter with packet lock. Holds the
//            last-granted pointer, IDLE/LOCKED state and the locked channel;
//            produces a one-hot grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter4
  import mux4_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic [N_CH-1:0] i_valid,
  input  wire logic [N_CH-1:0] i_last,
  input  wire logic            i_load,
  output logic      [N_CH-1:0] o_grant
);

  arb_state_t       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_lock_ch;

  logic [SEL_W:0]   w_pick;
  logic [SEL_W-1:0] w_gidx;
  logic             w_xfer;
  logic             w_glast;

  // Grant selection: locked channel only while LOCKED, else round-robin.
  always_comb begin
    w_pick  = rr_pick(i_valid, r_ptr);
    o_grant = '0;
    if (r_state == LOCKED) begin
      if (i_valid[r_lock_ch]) o_grant[r_lock_ch] = 1'b1;
    end else if (w_pick[SEL_W]) begin
      o_grant[w_pick[SEL_W-1:0]] = 1'b1;
    end
  end

  assign w_gidx  = onehot_idx(o_grant);
  assign w_xfer  = i_load & (|o_grant);
  assign w_glast = i_last[w_gidx];

  // State machine: pointer follows every accepted word; a non-final word
  // taken in IDLE locks onto its channel until that channel's final word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= SEL_W'(N_CH - 1);
      r_lock_ch <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_gidx;
      case (r_state)
        IDLE: begin
          if (!w_glast) begin
            r_state   <= LOCKED;
            r_lock_ch <= w_gidx;
          end
        end
        LOCKED: begin
          if (w_glast) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux4_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr
// Purpose  : 4:1 packet multiplexer with round-robin arbitration, packet
//            lock and a single registered output stage (1-cycle latency,
//            full throughput).
// Revision : 1.0
// ============================================================================
module mux4_rr
  import mux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic clk,
  input  wire logic rst_n,
  mux4_rr_if.slave  bus
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_last;

  logic             w_load;
  logic [N_CH-1:0]  w_grant;
  logic [N_CH-1:0]  w_ready;
  logic             w_xfer;
  logic [SEL_W-1:0] w_sel;
  logic [WIDTH-1:0] w_data;
  logic             w_last;

  // rst_n gating keeps every in_ready low while reset is held.
  assign w_load  = rst_n & (~r_out_valid | bus.out_ready);

  rr_arbiter4 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.in_valid),
    .i_last  (bus.in_last),
    .i_load  (w_load),
    .o_grant (w_grant)
  );

  assign w_ready = w_grant & {N_CH{w_load}};
  assign w_xfer  = |w_ready;
  assign w_sel   = onehot_idx(w_grant);
  assign w_data  = bus.in_data[w_sel*WIDTH +: WIDTH];
  assign w_last  = bus.in_last[w_sel];

  // Output register: refill whenever empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_data;
        r_out_sel  <= w_sel;
        r_out_last <= w_last;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;
  assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr
// Purpose  : Self-checking bench for mux4_rr: directed scenarios followed by
//            random traffic, compared against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_mux4_rr;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  mux4_rr_if #(.WIDTH(W)) bus ();

  mux4_rr #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // Behavioural model state
  int         m_ptr;
  bit         m_locked;
  int         m_lock;
  logic       m_ov;
  logic [W-1:0] m_data;
  logic [1:0] m_sel;
  logic       m_last;
  logic [3:0] cur_v;
  logic [W-1:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (m_locked) return cur_v[m_lock] ? m_lock : -1;
    for (int i = 1; i <= 4; i++) begin
      if (cur_v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 3; m_locked = 0; m_lock = 0;
    m_ov = 0; m_data = '0; m_sel = '0; m_last = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_out_valid"}, 32'(bus.out_valid), 32'(m_ov));
    check({pfx, "_out_data"},  32'(bus.out_data),  32'(m_data));
    check({pfx, "_out_sel"},   32'(bus.out_sel),   32'(m_sel));
    check({pfx, "_out_last"},  32'(bus.out_last),  32'(m_last));
    check({pfx, "_locked"},    32'(u_dut.u_arb.r_state), 32'(m_locked));
    check({pfx, "_ptr"},       32'(u_dut.u_arb.r_ptr),   32'(m_ptr));
  endtask

  // One clock cycle of traffic, checked before and after the edge.
  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic r);
    logic [31:0] d;
    logic [3:0]  exp_rdy;
    bit          load;
    int          g;
    @(negedge clk);
    d = $urandom;
    cur_v = v;
    bus.in_valid = v; bus.in_last = l; bus.out_ready = r; bus.in_data = d;
    #1;
    load = !m_ov || r;
    g = model_grant();
    exp_rdy = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (load) begin
      if (g >= 0) begin
        m_ov = 1; m_data = d[g*W +: W]; m_sel = g[1:0]; m_last = l[g];
        if (!m_locked && !l[g]) begin
          m_locked = 1; m_lock = g;
        end else if (m_locked && l[g]) begin
          m_locked = 0;
        end
        m_ptr = g;
      end else begin
        m_ov = 0;
      end
    end
    check_outputs("cyc");
  endtask

  // Asynchronous reset asserted mid-cycle with every channel requesting.
  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_in_ready", 32'(bus.in_ready), 32'h0);
    check_outputs("rst_hold");
    @(negedge clk);
    bus.in_valid = 4'h0;
    rst_n = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.in_valid = '0; bus.in_last = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    cur_v = '0;
    model_reset();

    // Reset and first grants: channel 0 first, then rotating
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(4'hF, 4'hF, 1'b1);
      check("first_sel", 32'(bus.out_sel), 32'(k % 4));
    end

    // Backpressure: word held, no in_ready, then delivered
    held = m_data;
    for (int k = 0; k < 3; k++) begin
      cyc(4'hF, 4'hF, 1'b0);
      check("bp_data_hold", 32'(bus.out_data), 32'(held));
      check("bp_valid", 32'(bus.out_valid), 32'h1);
    end
    cyc(4'hF, 4'hF, 1'b1);

    // Packet lock on channel 2 with all other channels competing
    cyc(4'b0010, 4'hF, 1'b1);
    cyc(4'hF, 4'b1011, 1'b1); check("lock_w1", 32'(bus.out_sel), 32'd2);
    cyc(4'hF, 4'b1011, 1'b1); check("lock_w2", 32'(bus.out_sel), 32'd2);
    cyc(4'hF, 4'hF, 1'b1);    check("lock_w3", 32'(bus.out_sel), 32'd2);
    check("lock_w3_last", 32'(bus.out_last), 32'h1);
    cyc(4'hF, 4'hF, 1'b1);    check("after_lock", 32'(bus.out_sel), 32'd3);

    // Lock stall: channel 2 drops valid for two cycles mid-packet
    cyc(4'b0010, 4'hF, 1'b1);
    cyc(4'hF, 4'b1011, 1'b1);
    cyc(4'b1011, 4'hF, 1'b1);
    cyc(4'b1011, 4'hF, 1'b1);
    check("stall_valid", 32'(bus.out_valid), 32'h0);
    check("stall_locked", 32'(u_dut.u_arb.r_state), 32'h1);
    cyc(4'hF, 4'hF, 1'b1);    check("stall_resume", 32'(bus.out_sel), 32'd2);

    // Wrap-around: ptr=3, only channel 1 valid
    cyc(4'b1000, 4'hF, 1'b1);
    cyc(4'b0010, 4'hF, 1'b1);
    check("wrap_sel", 32'(bus.out_sel), 32'd1);
    check("wrap_ptr", 32'(u_dut.u_arb.r_ptr), 32'd1);

    // Reset in the middle of a channel-1 packet
    cyc(4'b0010, 4'h0, 1'b1);
    cyc(4'b0010, 4'h0, 1'b1);
    do_reset();
    cyc(4'b0011, 4'h0, 1'b1);
    check("post_rst_sel", 32'(bus.out_sel), 32'd0);

    // Random traffic with random backpressure and one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
